// File: rtl/board_timer.sv
// board_timer: APB machine timer with a prescaled 64-bit utime counter,
// per-hart 64-bit compare registers, per-hart timer and software interrupts,
// an atomic two-word utime read through a shadow register and a writable utime.
// An optional watchdog is built only when BOARD_TIMER_WATCHDOG_EN is defined;
// without it, 0x0C/0x10 read 0, writes to them are dropped and wdt_reset is 0.
//
// APB handshake: zero wait states, so PREADY is tied high. A write commits on
// the clk edge where PSEL&PENABLE&PWRITE is high. A read is recognised while
// PSEL&PENABLE&~PWRITE is high; PRDATA is combinational from PADDR, and
// side effects of a read (the shadow latch) happen on that same edge.
//
// Register map (byte offsets, PADDR[1:0] ignored):
//   0x00 utime[31:0] (read also latches utime[63:32] into shadow_hi)
//   0x04 shadow_hi on read, utime[63:32] on write
//   0x08 soft_irq[NUM_HARTS-1:0]
//   0x0C watchdog control, bit0 = enable
//   0x10 watchdog reload / kick, reads the live count
//   0x20+8h cmp[h][31:0], 0x24+8h cmp[h][63:32]

module board_timer #(
   parameter int CLK_FREQ  = 48_000_000,
   parameter int TICK_FREQ = 1_000_000,
   parameter int NUM_HARTS = 2,
   parameter int WDT_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic [6:0]           apb_PADDR,
   input  logic                 apb_PSEL,
   input  logic                 apb_PENABLE,
   input  logic                 apb_PWRITE,
   input  logic [31:0]          apb_PWDATA,
   output logic                 apb_PREADY,
   output logic [31:0]          apb_PRDATA,
   output logic [63:0]          utime,
   output logic [NUM_HARTS-1:0] timer_irq,
   output logic [NUM_HARTS-1:0] soft_irq,
   output logic                 wdt_reset
);

   // Clocks per utime tick and the prescaler sizing derived from it.
   localparam int DIV = CLK_FREQ / TICK_FREQ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   // Word offsets of the fixed registers.
   localparam logic [4:0] IDX_TIME_LO = 5'd0;
   localparam logic [4:0] IDX_TIME_HI = 5'd1;
   localparam logic [4:0] IDX_SOFT    = 5'd2;
   localparam logic [4:0] IDX_WDT_CTL = 5'd3;
   localparam logic [4:0] IDX_WDT_CNT = 5'd4;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PW-1:0]          presc_q,     presc_d;
   logic [63:0]            utime_q,     utime_d;
   logic [31:0]            shadow_hi_q, shadow_hi_d;
   logic [63:0]            cmp_q [NUM_HARTS];
   logic [63:0]            cmp_d [NUM_HARTS];
   logic [NUM_HARTS-1:0]   timer_irq_q, timer_irq_d;
   logic [NUM_HARTS-1:0]   soft_irq_q,  soft_irq_d;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic [4:0] word_idx;
   logic       wr_en;
   logic       rd_en;
   logic       tick;
   logic       unused_paddr_bits;

   assign word_idx          = apb_PADDR[6:2];
   assign wr_en             = apb_PSEL & apb_PENABLE & apb_PWRITE;
   assign rd_en             = apb_PSEL & apb_PENABLE & ~apb_PWRITE;
   assign unused_paddr_bits = ^apb_PADDR[1:0];

   // The prescaler wrap is the 1 MHz tick shared by utime and the watchdog.
   assign tick = (presc_q == PRESC_LAST);

   // ------------------------------------------------------------------
   // Optional watchdog
   // ------------------------------------------------------------------
`ifdef BOARD_TIMER_WATCHDOG_EN
   logic                 wdt_en_q,    wdt_en_d;
   logic [WDT_WIDTH-1:0] wdt_cnt_q,   wdt_cnt_d;
   logic                 wdt_reset_q, wdt_reset_d;

   // Watchdog next state: a kick beats a same-edge tick, expiry is sticky.
   always_comb begin
      wdt_en_d    = wdt_en_q;
      wdt_cnt_d   = wdt_cnt_q;
      wdt_reset_d = wdt_reset_q;
      // Count down on ticks while enabled, holding at zero once there.
      if (wdt_en_q && tick && (wdt_cnt_q != '0)) begin
         wdt_cnt_d = wdt_cnt_q - WDT_WIDTH'(1);
      end
      if (wr_en && (word_idx == IDX_WDT_CNT)) begin
         wdt_cnt_d = apb_PWDATA[WDT_WIDTH-1:0];
      end
      if (wr_en && (word_idx == IDX_WDT_CTL)) begin
         wdt_en_d = apb_PWDATA[0];
      end
      // Only nreset releases the request; disabling the watchdog does not.
      if (wdt_en_q && (wdt_cnt_q == '0)) begin
         wdt_reset_d = 1'b1;
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         wdt_en_q    <= 1'b0;
         wdt_cnt_q   <= '1;
         wdt_reset_q <= 1'b0;
      end else begin
         wdt_en_q    <= wdt_en_d;
         wdt_cnt_q   <= wdt_cnt_d;
         wdt_reset_q <= wdt_reset_d;
      end
   end

   assign wdt_reset = wdt_reset_q;
`else
   assign wdt_reset = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------

   // Prescaler and utime: software writes to either half win over a tick
   // on the same edge and restart the prescaler so the next tick is a full
   // period after the write.
   always_comb begin
      presc_d = tick ? '0 : (presc_q + PRESC_ONE);
      utime_d = tick ? (utime_q + 64'd1) : utime_q;
      if (wr_en && (word_idx == IDX_TIME_LO)) begin
         utime_d = {utime_q[63:32], apb_PWDATA};
         presc_d = '0;
      end else if (wr_en && (word_idx == IDX_TIME_HI)) begin
         utime_d = {apb_PWDATA, utime_q[31:0]};
         presc_d = '0;
      end
   end

   // Shadow of the high word, captured by each read of the low word so a
   // lo-then-hi read pair sees one consistent 64-bit value.
   always_comb begin
      shadow_hi_d = shadow_hi_q;
      if (rd_en && (word_idx == IDX_TIME_LO)) begin
         shadow_hi_d = utime_q[63:32];
      end
   end

   // Compare registers, written one 32-bit half at a time.
   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         cmp_d[h] = cmp_q[h];
         if (wr_en && (word_idx == 5'(8 + 2 * h))) begin
            cmp_d[h][31:0] = apb_PWDATA;
         end
         if (wr_en && (word_idx == 5'(9 + 2 * h))) begin
            cmp_d[h][63:32] = apb_PWDATA;
         end
      end
   end

   // Timer interrupts: unsigned 64-bit compare on the current registers.
   always_comb begin
      timer_irq_d = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         timer_irq_d[h] = (utime_q >= cmp_q[h]);
      end
   end

   // Software interrupt register.
   always_comb begin
      soft_irq_d = soft_irq_q;
      if (wr_en && (word_idx == IDX_SOFT)) begin
         soft_irq_d = apb_PWDATA[NUM_HARTS-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------

   // Combinational read data; anything not decoded reads as zero.
   always_comb begin
      apb_PRDATA = '0;
      case (word_idx)
         IDX_TIME_LO: apb_PRDATA = utime_q[31:0];
         IDX_TIME_HI: apb_PRDATA = shadow_hi_q;
         IDX_SOFT:    apb_PRDATA[NUM_HARTS-1:0] = soft_irq_q;
`ifdef BOARD_TIMER_WATCHDOG_EN
         IDX_WDT_CTL: apb_PRDATA[0] = wdt_en_q;
         IDX_WDT_CNT: apb_PRDATA[WDT_WIDTH-1:0] = wdt_cnt_q;
`endif
         default: begin
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (word_idx == 5'(8 + 2 * h)) begin
                  apb_PRDATA = cmp_q[h][31:0];
               end
               if (word_idx == 5'(9 + 2 * h)) begin
                  apb_PRDATA = cmp_q[h][63:32];
               end
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------

   // Timer state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         presc_q     <= '0;
         utime_q     <= '0;
         shadow_hi_q <= '0;
         timer_irq_q <= '0;
         soft_irq_q  <= '0;
         for (int h = 0; h < NUM_HARTS; h++) begin
            cmp_q[h] <= '1;
         end
      end else begin
         presc_q     <= presc_d;
         utime_q     <= utime_d;
         shadow_hi_q <= shadow_hi_d;
         timer_irq_q <= timer_irq_d;
         soft_irq_q  <= soft_irq_d;
         for (int h = 0; h < NUM_HARTS; h++) begin
            cmp_q[h] <= cmp_d[h];
         end
      end
   end

   assign apb_PREADY = 1'b1;
   assign utime      = utime_q;
   assign timer_irq  = timer_irq_q;
   assign soft_irq   = soft_irq_q;

endmodule

// File: tb/tb_board_timer.sv
// tb_board_timer: directed bench for board_timer at DIV=48, NUM_HARTS=2.
// Inputs are driven and outputs sampled on the falling edge; each APB
// access takes two rising edges and a write commits on the second one.

module tb_board_timer;

   logic        clk;
   logic        nreset;
   logic [6:0]  paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic [63:0] utime;
   logic [1:0]  timer_irq;
   logic [1:0]  soft_irq;
   logic        wdt_reset;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];

   board_timer #(
      .CLK_FREQ (48_000_000),
      .TICK_FREQ(1_000_000),
      .NUM_HARTS(2),
      .WDT_WIDTH(24)
   ) dut (
      .clk        (clk),
      .nreset     (nreset),
      .apb_PADDR  (paddr),
      .apb_PSEL   (psel),
      .apb_PENABLE(penable),
      .apb_PWRITE (pwrite),
      .apb_PWDATA (pwdata),
      .apb_PREADY (pready),
      .apb_PRDATA (prdata),
      .utime      (utime),
      .timer_irq  (timer_irq),
      .soft_irq   (soft_irq),
      .wdt_reset  (wdt_reset)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      nreset  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      repeat (3) @(negedge clk);
      nreset = 1'b1;
   endtask

   // Driver tasks (called on a falling edge, return on a falling edge)
   task automatic apb_write(input logic [6:0] addr, input logic [31:0] data);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = addr;
      pwdata  = data;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic apb_read(input logic [6:0] addr, output logic [31:0] data);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = addr;
      @(negedge clk);
      penable = 1'b1;
      data    = prdata;
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   // Reset values, free running count and reset compare contents.
   task automatic test_reset();
      logic [31:0] rd;
      do_reset();
      n_checks++;
      if (utime !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_utime: got %h want %h", utime, 64'd0);
      end
      n_checks++;
      if (timer_irq !== 2'b00 || soft_irq !== 2'b00 || wdt_reset !== 1'b0 || pready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs: got tirq=%b sirq=%b wdt=%b rdy=%b want 00 00 0 1",
                  timer_irq, soft_irq, wdt_reset, pready);
      end
      repeat (480) @(negedge clk);
      n_checks++;
      if (utime !== 64'd10) begin
         n_fail++;
         $display("FAIL free_run_480: got %0d want 10", utime);
      end
      n_checks++;
      if (timer_irq !== 2'b00) begin
         n_fail++;
         $display("FAIL free_run_irq: got %b want 00", timer_irq);
      end
      apb_read(7'h20, rd);
      n_checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL reset_cmp0_lo: got %h want ffffffff", rd);
      end
      apb_read(7'h24, rd);
      n_checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL reset_cmp0_hi: got %h want ffffffff", rd);
      end
      apb_read(7'h04, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_shadow: got %h want 0", rd);
      end
   endtask

   // utime writes, carry into the high word and the shadowed read pair.
   task automatic test_utime_write();
      logic [31:0] rd;
      apb_write(7'h00, 32'hFFFF_FFFE);
      apb_write(7'h04, 32'h0000_0001);
      repeat (96) @(negedge clk);
      n_checks++;
      if (utime !== 64'h2_0000_0000) begin
         n_fail++;
         $display("FAIL utime_carry: got %h want 0000000200000000", utime);
      end
      repeat (48) @(negedge clk);
      n_checks++;
      if (utime !== 64'h2_0000_0001) begin
         n_fail++;
         $display("FAIL utime_3ticks: got %h want 0000000200000001", utime);
      end
      apb_read(7'h00, rd);
      n_checks++;
      if (rd !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL read_lo: got %h want 00000001", rd);
      end
      apb_read(7'h04, rd);
      n_checks++;
      if (rd !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL read_hi_shadow: got %h want 00000002", rd);
      end
      // Changing utime[63:32] must not disturb the already latched shadow.
      apb_write(7'h04, 32'h0000_0005);
      apb_read(7'h04, rd);
      n_checks++;
      if (rd !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL shadow_hold: got %h want 00000002", rd);
      end
      n_checks++;
      if (utime[63:32] !== 32'h0000_0005) begin
         n_fail++;
         $display("FAIL utime_hi_write: got %h want 00000005", utime[63:32]);
      end
   endtask

   // Compare on hart 1 at 100: interrupt one clock after utime reaches it.
   task automatic test_cmp_irq();
      logic [31:0] rd;
      bit          seen;
      apb_write(7'h04, 32'h0);
      apb_write(7'h00, 32'h0);
      apb_write(7'h2C, 32'hFFFF_FFFF);
      apb_write(7'h28, 32'd100);
      apb_write(7'h2C, 32'h0);
      apb_read(7'h28, rd);
      n_checks++;
      if (rd !== 32'd100) begin
         n_fail++;
         $display("FAIL cmp1_lo_readback: got %h want 00000064", rd);
      end
      apb_read(7'h2C, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL cmp1_hi_readback: got %h want 0", rd);
      end
      n_checks++;
      if (timer_irq !== 2'b00) begin
         n_fail++;
         $display("FAIL cmp1_early: got %b want 00 at utime %0d", timer_irq, utime);
      end
      seen = 1'b0;
      for (int i = 0; i < 6000 && !seen; i++) begin
         @(negedge clk);
         if (utime == 64'd100) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL cmp1_timeout: utime got %0d want 100", utime);
      end else begin
         n_checks++;
         if (timer_irq !== 2'b00) begin
            n_fail++;
            $display("FAIL cmp1_latency: got %b want 00 on first cycle of utime=100", timer_irq);
         end
         @(negedge clk);
         n_checks++;
         if (timer_irq !== 2'b10) begin
            n_fail++;
            $display("FAIL cmp1_fire: got %b want 10", timer_irq);
         end
      end
   endtask

   // The compare must be unsigned across bit 63.
   task automatic test_unsigned_cmp();
      apb_write(7'h24, 32'hFFFF_FFFF);
      apb_write(7'h20, 32'h0);
      apb_write(7'h24, 32'h8000_0000);
      apb_write(7'h04, 32'h7FFF_FFFF);
      apb_write(7'h00, 32'h0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (timer_irq[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL unsigned_below: got %b want 0", timer_irq[0]);
      end
      apb_write(7'h04, 32'h8000_0000);
      n_checks++;
      if (timer_irq[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL unsigned_latency: got %b want 0", timer_irq[0]);
      end
      @(negedge clk);
      n_checks++;
      if (timer_irq[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL unsigned_at: got %b want 1", timer_irq[0]);
      end
   endtask

   // A utime write landing on a prescaler wrap drops that tick and restarts the prescaler.
   task automatic test_write_tick_collision();
      apb_write(7'h04, 32'h0000_0007);
      repeat (46) @(negedge clk);
      apb_write(7'h00, 32'h0000_1234);
      n_checks++;
      if (utime !== 64'h7_0000_1234) begin
         n_fail++;
         $display("FAIL collide_value: got %h want 0000000700001234", utime);
      end
      repeat (47) @(negedge clk);
      n_checks++;
      if (utime !== 64'h7_0000_1234) begin
         n_fail++;
         $display("FAIL collide_presc_hold: got %h want 0000000700001234", utime);
      end
      @(negedge clk);
      n_checks++;
      if (utime !== 64'h7_0000_1235) begin
         n_fail++;
         $display("FAIL collide_presc_wrap: got %h want 0000000700001235", utime);
      end
   endtask

   // Software interrupt register.
   task automatic test_soft_irq();
      logic [31:0] rd;
      apb_write(7'h08, 32'h3);
      n_checks++;
      if (soft_irq !== 2'b11) begin
         n_fail++;
         $display("FAIL soft_irq_3: got %b want 11", soft_irq);
      end
      apb_write(7'h08, 32'h1);
      n_checks++;
      if (soft_irq !== 2'b01) begin
         n_fail++;
         $display("FAIL soft_irq_1: got %b want 01", soft_irq);
      end
      apb_read(7'h08, rd);
      n_checks++;
      if (rd !== 32'h1) begin
         n_fail++;
         $display("FAIL soft_irq_read: got %h want 00000001", rd);
      end
      apb_write(7'h08, 32'hFFFF_FFFE);
      apb_read(7'h08, rd);
      n_checks++;
      if (rd !== 32'h2 || soft_irq !== 2'b10) begin
         n_fail++;
         $display("FAIL soft_irq_upper: got rd=%h sirq=%b want 00000002 10", rd, soft_irq);
      end
   endtask

   // Unmapped offsets and harts beyond NUM_HARTS read 0 and ignore writes.
   task automatic test_regmap();
      logic [6:0]  addrs [4];
      logic [31:0] rd;
      logic [31:0] exp;
      addrs[0] = 7'h14;
      addrs[1] = 7'h30;
      addrs[2] = 7'h34;
      addrs[3] = 7'h7C;
      for (int i = 0; i < 4; i++) begin
         apb_write(addrs[i], 32'hA5A5_5A5A);
         exp_q.push_back(32'h0);
      end
      for (int i = 0; i < 4; i++) begin
         apb_read(addrs[i], rd);
         exp = exp_q.pop_front();
         n_checks++;
         if (rd !== exp) begin
            n_fail++;
            $display("FAIL unmapped_read addr %h: got %h want %h", addrs[i], rd, exp);
         end
      end
      // cmp[0] must not have been touched by the hart-2 writes.
      apb_read(7'h24, rd);
      n_checks++;
      if (rd !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL cmp0_untouched: got %h want 80000000", rd);
      end
   endtask

`ifdef BOARD_TIMER_WATCHDOG_EN
   // Watchdog expiry is sticky until nreset.
   task automatic test_watchdog();
      logic [31:0] rd;
      int          n;
      bit          seen;
      apb_write(7'h10, 32'd5);
      apb_write(7'h0C, 32'h1);
      seen = 1'b0;
      n    = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (wdt_reset === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL wdt_timeout: got wdt_reset=%b want 1 within 400 clk", wdt_reset);
      end
      n_checks++;
      if (n < 194 || n > 241) begin
         n_fail++;
         $display("FAIL wdt_delay: got %0d clk want 194..241", n);
      end
      repeat (100) @(negedge clk);
      n_checks++;
      if (wdt_reset !== 1'b1) begin
         n_fail++;
         $display("FAIL wdt_sticky: got %b want 1", wdt_reset);
      end
      apb_write(7'h0C, 32'h0);
      apb_write(7'h10, 32'd100);
      apb_read(7'h10, rd);
      n_checks++;
      if (rd !== 32'd100) begin
         n_fail++;
         $display("FAIL wdt_kick_read: got %h want 00000064", rd);
      end
      n_checks++;
      if (wdt_reset !== 1'b1) begin
         n_fail++;
         $display("FAIL wdt_kick_sticky: got %b want 1", wdt_reset);
      end
      do_reset();
      n_checks++;
      if (wdt_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL wdt_nreset: got %b want 0", wdt_reset);
      end
   endtask
`else
   // Without the watchdog its registers are inert.
   task automatic test_watchdog();
      logic [31:0] rd;
      apb_write(7'h10, 32'd5);
      apb_write(7'h0C, 32'h1);
      apb_read(7'h0C, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL wdt_ctl_absent: got %h want 0", rd);
      end
      apb_read(7'h10, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL wdt_cnt_absent: got %h want 0", rd);
      end
      repeat (300) @(negedge clk);
      n_checks++;
      if (wdt_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL wdt_reset_absent: got %b want 0", wdt_reset);
      end
   endtask
`endif

   // Sequence and final report
   initial begin
      test_reset();
      test_utime_write();
      test_cmp_irq();
      test_unsigned_cmp();
      test_write_tick_collision();
      test_soft_irq();
      test_regmap();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
